score_bcd_sequencer: RTL

- Sequential binary-to-BCD converter and frame-synchronised committer for the on-screen score/lines/level number renderer.
- Accepts a binary value from game logic over a valid/ready handshake and converts it to 8 packed BCD nibbles with an iterative double-dabble over IN_W cycles.
- Optionally blanks leading zeros, then commits the result to the renderer's 32-bit number input only on a frame tick, so a frame never shows a half-updated value.

---
 rtl/score_bcd_sequencer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/score_bcd_sequencer.sv
// score_bcd_sequencer: iterative binary-to-BCD converter (double-dabble, one bit
// per cycle) with optional leading-zero blanking. The result reaches the number
// renderer only on a frame tick, so a frame never shows a half-updated value.
module score_bcd_sequencer #(
    parameter int unsigned IN_W          = 27,
    parameter int unsigned DIGITS        = 8,
    parameter bit          SYNC_TO_FRAME = 1'b1,
    parameter bit          BLANK_LEADING = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [IN_W-1:0]       value_in,
    input  logic                  value_valid,
    output logic                  value_ready,
    input  logic                  frame_tick,
    output logic [4*DIGITS-1:0]   number_out,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;

    // Largest displayable value, 10^DIGITS - 1, computed at elaboration time.
    function automatic logic [63:0] max_display();
        logic [63:0] p;
        p = 64'd1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

    localparam logic [63:0] MAX_VAL = max_display();

    // Zero digits above the highest nonzero digit become 4'hF; digit 0 is never blanked.
    function automatic logic [BCD_W-1:0] blank_leading(input logic [BCD_W-1:0] d);
        logic [BCD_W-1:0] r;
        logic             seen;
        r    = d;
        seen = 1'b0;
        for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
            if (!seen && (d[4*i +: 4] == 4'd0)) begin
                r[4*i +: 4] = 4'hF;
            end else begin
                seen = 1'b1;
            end
        end
        return r;
    endfunction

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_WAIT
    } state_t;

    state_t                  r_state;
    logic [IN_W-1:0]         r_bin;
    logic [BCD_W-1:0]        r_bcd;
    logic [CNT_W-1:0]        r_cnt;
    logic [BCD_W-1:0]        r_number;
    logic                    r_busy;
    logic                    r_done;

    state_t                  w_state_next;
    logic                    w_accept;
    logic                    w_conv_last;
    logic                    w_commit;
    logic [IN_W-1:0]         w_sat;
    logic [BCD_W-1:0]        w_adj;
    logic [BCD_W+IN_W-1:0]   w_shift;
    logic [BCD_W-1:0]        w_step_bcd;
    logic [IN_W-1:0]         w_step_bin;
    logic [BCD_W-1:0]        w_result;
    logic [BCD_W-1:0]        w_commit_val;

    assign w_accept    = (r_state == S_IDLE) && value_valid;
    assign w_conv_last = (r_state == S_CONV) && (r_cnt == CNT_W'(IN_W - 1));
    assign w_sat       = (64'(value_in) > MAX_VAL) ? MAX_VAL[IN_W-1:0] : value_in;

    // Double-dabble adjust: every BCD nibble >= 5 gets +3, no carry between nibbles.
    always_comb begin
        w_adj = r_bcd;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    assign w_shift    = {w_adj, r_bin} << 1;
    assign w_step_bcd = w_shift[BCD_W+IN_W-1:IN_W];
    assign w_step_bin = w_shift[IN_W-1:0];

    // An unsynchronised commit happens on the final CONV edge, so it takes the
    // freshly stepped value rather than the registered one.
    assign w_result     = (r_state == S_CONV) ? w_step_bcd : r_bcd;
    assign w_commit_val = BLANK_LEADING ? blank_leading(w_result) : w_result;

    // Next-state and commit decision.
    always_comb begin
        w_state_next = r_state;
        w_commit     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (value_valid) begin
                    w_state_next = S_CONV;
                end
            end
            S_CONV: begin
                if (w_conv_last) begin
                    if (SYNC_TO_FRAME) begin
                        w_state_next = S_WAIT;
                    end else begin
                        w_state_next = S_IDLE;
                        w_commit     = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (frame_tick) begin
                    w_state_next = S_IDLE;
                    w_commit     = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Conversion datapath: load saturated value on transfer, step once per CONV cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin <= '0;
            r_bcd <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_bin <= w_sat;
            r_bcd <= '0;
            r_cnt <= '0;
        end else if (r_state == S_CONV) begin
            r_bin <= w_step_bin;
            r_bcd <= w_step_bcd;
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Registered outputs: committed number, one-cycle done pulse, busy tracking the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_number <= '0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            if (w_commit) begin
                r_number <= w_commit_val;
            end
            r_done <= w_commit;
            r_busy <= (w_state_next != S_IDLE);
        end
    end

    assign value_ready = (r_state == S_IDLE);
    assign number_out  = r_number;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule
